// File: rtl/cipher_byte_sequencer_pkg.sv
// Shared definitions for the cipher byte sequencer: block geometry and FSM state encodings.
package cipher_byte_sequencer_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam logic [3:0]  LAST_BYTE_IDX   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cipher_byte_sequencer_hold_timer.sv
// Per-byte hold counter: counts enabled cycles and flags the last cycle of the hold window.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Hold counter; only clr (driven by advance) returns it to zero, so it never overflows.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == CNT_LAST);

endmodule

// File: rtl/cipher_byte_sequencer.sv
// Captures one 128-bit cipher result and presents it byte by byte (byte 0 first) to the display path.
module cipher_byte_sequencer
  import cipher_byte_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:AES_BLOCK_BITS-1] block_in,
  input  logic                      block_valid,
  output logic                      block_ready,
  input  logic                      auto_mode,
  input  logic                      step,
  output logic [7:0]                byte_out,
  output logic [3:0]                byte_index,
  output logic                      byte_valid,
  output logic                      done
);

  seq_state_t                state_r;
  logic [0:AES_BLOCK_BITS-1] shadow_r;
  logic [3:0]                index_r;
  logic [3:0]                next_index_s;
  logic                      step_q_r;
  logic                      step_rise_s;
  logic                      in_show_s;
  logic                      expire_s;
  logic                      advance_s;
  logic                      transfer_s;
  logic                      timer_en_s;
  logic                      timer_clr_s;

  assign block_ready = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign byte_index  = index_r;

  // Advance decode: a timer expiry and a step edge in the same cycle count as a single advance.
  always_comb begin
    in_show_s    = (state_r == ST_SHOW);
    step_rise_s  = step & ~step_q_r;
    transfer_s   = block_valid & block_ready;
    next_index_s = index_r + 4'd1;
    if (in_show_s) begin
      advance_s = (auto_mode & expire_s) | step_rise_s;
    end else begin
      advance_s = 1'b0;
    end
    timer_en_s  = in_show_s & auto_mode;
    timer_clr_s = ~in_show_s | ~auto_mode | advance_s;
  end

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en_s),
    .clr    (timer_clr_s),
    .expire (expire_s)
  );

  // Sequencer FSM with registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shadow_r   <= {AES_BLOCK_BITS{1'b0}};
      index_r    <= 4'd0;
      step_q_r   <= 1'b0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_q_r <= step;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (transfer_s) begin
            state_r    <= ST_SHOW;
            shadow_r   <= block_in;
            index_r    <= 4'd0;
            byte_out   <= block_in[0 +: 8];
            byte_valid <= 1'b1;
            done       <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHOW: begin
          // Index 15 never wraps; finishing the block parks the display on the last byte.
          if (advance_s) begin
            if (index_r != LAST_BYTE_IDX) begin
              index_r  <= next_index_s;
              byte_out <= shadow_r[{next_index_s, 3'b000} +: 8];
            end else begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end
          end else begin
            state_r <= ST_SHOW;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          index_r    <= 4'd0;
          byte_out   <= 8'd0;
          byte_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_byte_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural display model.
module tb_cipher_byte_sequencer;

  localparam int HOLD = 4;
  localparam logic [127:0] K1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic         auto_mode;
  logic         step;
  logic [7:0]   byte_out;
  logic [3:0]   byte_index;
  logic         byte_valid;
  logic         done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cipher_byte_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .auto_mode   (auto_mode),
    .step        (step),
    .byte_out    (byte_out),
    .byte_index  (byte_index),
    .byte_valid  (byte_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: 0 = no block, 1 = showing, 2 = all shown
  int         m_phase = 0;
  int         m_idx   = 0;
  int         m_age   = 0;
  bit         m_prev_step = 1'b0;
  logic [7:0] m_bytes [16];

  always @(posedge clk) begin
    bit rise;
    bit fire;
    if (rst) begin
      m_phase = 0; m_idx = 0; m_age = 0; m_prev_step = 1'b0;
    end else begin
      rise = step && !m_prev_step;
      m_prev_step = step;
      if (m_phase == 1) begin
        fire = (auto_mode && m_age == HOLD - 1) || rise;
        if (fire) begin
          m_age = 0;
          if (m_idx == 15) m_phase = 2;
          else m_idx = m_idx + 1;
        end else begin
          m_age = auto_mode ? m_age + 1 : 0;
        end
      end else if (block_valid) begin
        for (int k = 0; k < 16; k++) m_bytes[k] = block_in[127 - 8*k -: 8];
        m_phase = 1; m_idx = 0; m_age = 0;
      end
    end
    #1;
    check("byte_out",    {24'd0, byte_out},    (m_phase == 0) ? 32'd0 : {24'd0, m_bytes[m_idx]});
    check("byte_index",  {28'd0, byte_index},  (m_phase == 0) ? 32'd0 : m_idx);
    check("byte_valid",  {31'd0, byte_valid},  {31'd0, m_phase != 0});
    check("done",        {31'd0, done},        {31'd0, m_phase == 2});
    check("block_ready", {31'd0, block_ready}, {31'd0, m_phase != 1});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [127:0] blk);
    block_in = blk; block_valid = 1'b1;
    tick(1);
    block_valid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(1);
    step = 1'b0; tick(1);
  endtask

  initial begin
    rst = 1'b1; block_in = 128'd0; block_valid = 1'b0; auto_mode = 1'b0; step = 1'b0;
    tick(2);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_ready", {31'd0, block_ready}, 32'd1);
    rst = 1'b0;

    // Auto mode walk through a whole block
    auto_mode = 1'b1;
    load(K1);
    check("t1_first_byte", {24'd0, byte_out}, 32'h69);
    check("t1_first_idx", {28'd0, byte_index}, 32'd0);
    tick(4);
    check("t1_second_byte", {24'd0, byte_out}, 32'hc4);
    tick(59);
    check("t1_last_byte", {24'd0, byte_out}, 32'h5a);
    check("t1_not_done", {31'd0, done}, 32'd0);
    tick(1);
    check("t1_done", {31'd0, done}, 32'd1);
    tick(6);
    check("t1_done_hold_idx", {28'd0, byte_index}, 32'd15);

    // Manual stepping
    auto_mode = 1'b0;
    load(K1);
    pulse_step(); pulse_step(); pulse_step();
    check("t2_idx3", {28'd0, byte_index}, 32'd3);
    check("t2_byte3", {24'd0, byte_out}, 32'hd8);
    step = 1'b1; tick(10); step = 1'b0; tick(1);
    check("t2_held_step_idx", {28'd0, byte_index}, 32'd4);
    check("t2_held_step_byte", {24'd0, byte_out}, 32'h6a);

    // Valid ignored while showing
    block_in = K2; block_valid = 1'b1; tick(5); block_valid = 1'b0;
    check("t4_shadow_kept", {24'd0, byte_out}, 32'h6a);

    // Step edge coinciding with timer expiry
    auto_mode = 1'b1;
    tick(3);
    step = 1'b1; tick(1); step = 1'b0;
    check("t3_single_adv", {28'd0, byte_index}, 32'd5);
    tick(2);
    check("t3_no_double", {28'd0, byte_index}, 32'd5);

    // Auto off mid-hold restarts the hold window
    auto_mode = 1'b0; tick(1); auto_mode = 1'b1;
    tick(3);
    check("t6_still_held", {28'd0, byte_index}, 32'd5);
    tick(1);
    check("t6_advanced", {28'd0, byte_index}, 32'd6);

    // Reset mid-display
    tick(4);
    check("t5_idx7", {28'd0, byte_index}, 32'd7);
    rst = 1'b1; tick(1);
    check("t5_valid", {31'd0, byte_valid}, 32'd0);
    check("t5_byte", {24'd0, byte_out}, 32'd0);
    check("t5_idx", {28'd0, byte_index}, 32'd0);
    check("t5_ready", {31'd0, block_ready}, 32'd1);
    rst = 1'b0; auto_mode = 1'b0;

    // Reload from DONE
    load(K1);
    for (int i = 0; i < 16; i++) pulse_step();
    check("t4_done", {31'd0, done}, 32'd1);
    pulse_step();
    check("t4_no_wrap", {28'd0, byte_index}, 32'd15);
    load(K2);
    check("t4_reload_done", {31'd0, done}, 32'd0);
    check("t4_reload_byte", {24'd0, byte_out}, 32'h00);
    check("t4_reload_idx", {28'd0, byte_index}, 32'd0);
    pulse_step();
    check("t4_reload_byte1", {24'd0, byte_out}, 32'h11);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      block_valid = ($urandom_range(0, 7) == 0);
      block_in    = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
      step        = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    rst = 1'b0; block_valid = 1'b0; step = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
